// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and default width.
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_fa_slice.sv
// One-bit full adder with its recirculating carry flop; the carry loads cin
// on an accepted start and takes the slice carry-out on every RUN cycle.
module serial_fa_slice (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_cin,
    input  logic i_en,
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);

    logic r_carry;

    always_comb begin
        o_s = i_a ^ i_b ^ r_carry;
        o_c = (i_a & i_b) | (r_carry & (i_a ^ i_b));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else if (i_load) begin
            r_carry <= i_cin;
        end else if (i_en) begin
            r_carry <= o_c;
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: latches operands on start, feeds one bit pair per
// clock through serial_fa_slice, and publishes {cout,sum} with a one-cycle done.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-2:0] r_ss;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic             w_load;
    logic             w_run;
    logic             w_last;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_ss_next;

    assign w_load    = (r_state == ST_IDLE) && start;
    assign w_run     = (r_state == ST_RUN);
    assign w_last    = w_run && (r_cnt == CNT_W'(WIDTH - 1));
    // New sum bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
    assign w_ss_next = {w_s, r_ss};

    serial_fa_slice u_slice (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_cin  (cin),
        .i_en   (w_run),
        .i_a    (r_sa[0]),
        .i_b    (r_sb[0]),
        .o_s    (w_s),
        .o_c    (w_c)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // busy/done are decoded from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_ss   <= '0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_load) begin
            r_sa  <= a_in;
            r_sb  <= b_in;
            r_cnt <= '0;
        end else if (w_run) begin
            r_sa <= r_sa >> 1;
            r_sb <= r_sb >> 1;
            r_ss <= w_ss_next[WIDTH-1:1];
            if (w_last) begin
                r_cnt  <= '0;
                r_sum  <= w_ss_next;
                r_cout <= w_c;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: an 8-bit instance for directed cases and
// a 3-bit instance swept exhaustively; monitors pop expectations on each done.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // 8-bit instance
    logic       s8_start = 1'b0;
    logic [7:0] s8_a = '0;
    logic [7:0] s8_b = '0;
    logic       s8_cin = 1'b0;
    logic       s8_busy, s8_done, s8_cout;
    logic [7:0] s8_sum;

    // 3-bit instance
    logic       s3_start = 1'b0;
    logic [2:0] s3_a = '0;
    logic [2:0] s3_b = '0;
    logic       s3_cin = 1'b0;
    logic       s3_busy, s3_done, s3_cout;
    logic [2:0] s3_sum;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .a_in(s8_a), .b_in(s8_b),
        .cin(s8_cin), .busy(s8_busy), .done(s8_done), .sum(s8_sum), .cout(s8_cout)
    );

    serial_add_ctrl #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(s3_start), .a_in(s3_a), .b_in(s3_b),
        .cin(s3_cin), .busy(s3_busy), .done(s3_done), .sum(s3_sum), .cout(s3_cout)
    );

    int errors = 0;
    int checks = 0;

    logic [8:0] exp8_q[$];
    int         edge8_q[$];
    logic [3:0] exp3_q[$];
    int         edge3_q[$];

    // Earliest edge at which each DUT samples start in IDLE again (WIDTH+2 interval).
    int next8 = 0;
    int next3 = 0;

    logic [8:0] held8 = '0;
    logic [3:0] held3 = '0;
    int         bcnt8 = 0;
    int         bcnt3 = 0;
    logic       pdone8 = 1'b0;
    logic       pdone3 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One input cycle on the 8-bit DUT; an accepted start pushes its expectation.
    task automatic cycle8(input logic st, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic [8:0] exp);
        int e;
        @(negedge clk);
        s8_start = st;
        s8_a     = a;
        s8_b     = b;
        s8_cin   = ci;
        e = cyc + 1;
        if (st && e >= next8) begin
            exp8_q.push_back(exp);
            edge8_q.push_back(e);
            next8 = e + 10;
        end
    endtask

    task automatic idle8(input int n);
        for (int i = 0; i < n; i++) cycle8(1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
    endtask

    task automatic cycle3(input logic st, input logic [2:0] a, input logic [2:0] b,
                          input logic ci);
        int e;
        @(negedge clk);
        s3_start = st;
        s3_a     = a;
        s3_b     = b;
        s3_cin   = ci;
        e = cyc + 1;
        if (st && e >= next3) begin
            exp3_q.push_back(4'(a) + 4'(b) + 4'(ci));
            edge3_q.push_back(e);
            next3 = e + 5;
        end
    endtask

    // Monitor for the 8-bit DUT: result, latency, hold, pulse width, busy length.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s8_done) begin
                if (exp8_q.size() == 0) begin
                    check("done8_unexpected", 32'd1, 32'd0);
                end else begin
                    held8 = exp8_q.pop_front();
                    check("sum8", {23'd0, s8_cout, s8_sum}, {23'd0, held8});
                    check("lat8", cyc - edge8_q.pop_front(), 32'd8);
                end
                if (pdone8) check("done8_width", 32'd2, 32'd1);
            end else begin
                check("hold8", {23'd0, s8_cout, s8_sum}, {23'd0, held8});
            end
            if (s8_busy) begin
                bcnt8++;
            end else if (bcnt8 != 0) begin
                check("busy8_len", bcnt8, 32'd9);
                bcnt8 = 0;
            end
            pdone8 = s8_done;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (s3_done) begin
                if (exp3_q.size() == 0) begin
                    check("done3_unexpected", 32'd1, 32'd0);
                end else begin
                    held3 = exp3_q.pop_front();
                    check("sum3", {28'd0, s3_cout, s3_sum}, {28'd0, held3});
                    check("lat3", cyc - edge3_q.pop_front(), 32'd3);
                end
                if (pdone3) check("done3_width", 32'd2, 32'd1);
            end else begin
                check("hold3", {28'd0, s3_cout, s3_sum}, {28'd0, held3});
            end
            if (s3_busy) begin
                bcnt3++;
            end else if (bcnt3 != 0) begin
                check("busy3_len", bcnt3, 32'd4);
                bcnt3 = 0;
            end
            pdone3 = s3_done;
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: got cyc=%0d expected completion", cyc);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [7:0] ta, tb_v;
        logic       tc;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_sum8",  {23'd0, s8_cout, s8_sum}, 32'd0);
        check("rst_busy8", {30'd0, s8_busy, s8_done}, 32'd0);
        check("rst_sum3",  {28'd0, s3_cout, s3_sum}, 32'd0);
        check("rst_busy3", {30'd0, s3_busy, s3_done}, 32'd0);
        rst_n = 1'b1;

        // Basic add, carry ripple cases
        cycle8(1'b1, 8'h5A, 8'h3C, 1'b0, 9'h096);
        idle8(10);
        cycle8(1'b1, 8'hFF, 8'h01, 1'b0, 9'h100);
        idle8(10);
        cycle8(1'b1, 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        idle8(10);

        // start held high, operands changing every cycle
        for (int i = 0; i < 30; i++) begin
            ta   = 8'(i * 37 + 5);
            tb_v = 8'(i * 91 + 3);
            tc   = 1'(i);
            cycle8(1'b1, ta, tb_v, tc, 9'(ta) + 9'(tb_v) + 9'(tc));
        end
        idle8(12);

        // Start pulsed in the DONE cycle is ignored; the next IDLE start is taken
        cycle8(1'b1, 8'h20, 8'h03, 1'b1, 9'h024);
        idle8(8);
        cycle8(1'b1, 8'h77, 8'h77, 1'b0, 9'h0EE);
        cycle8(1'b1, 8'h80, 8'h80, 1'b1, 9'h101);
        idle8(12);

        // Asynchronous reset in the middle of 0x12+0x34
        cycle8(1'b1, 8'h12, 8'h34, 1'b0, 9'h046);
        idle8(4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp8_q.delete();
        edge8_q.delete();
        exp3_q.delete();
        edge3_q.delete();
        held8 = '0;
        held3 = '0;
        bcnt8 = 0;
        bcnt3 = 0;
        pdone8 = 1'b0;
        pdone3 = 1'b0;
        next8 = 0;
        next3 = 0;
        #1;
        check("abort_sum8",  {23'd0, s8_cout, s8_sum}, 32'd0);
        check("abort_busy8", {30'd0, s8_busy, s8_done}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_nodone8", {31'd0, s8_done}, 32'd0);
        rst_n = 1'b1;
        idle8(12);
        cycle8(1'b1, 8'h12, 8'h34, 1'b0, 9'h046);
        idle8(12);

        // 3-bit instance, every a, b, cin combination
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < 2; c++) begin
                    cycle3(1'b1, 3'(a), 3'(b), 1'(c));
                    repeat (4) cycle3(1'b0, 3'd0, 3'd0, 1'b0);
                end
            end
        end
        repeat (8) cycle3(1'b0, 3'd0, 3'd0, 1'b0);

        check("q8_drained", exp8_q.size(), 32'd0);
        check("q3_drained", exp3_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
